// File: rtl/alu_pkg.sv
// alu_pkg
// Shared encodings for the execute stage: the coarse ALU operation from the
// decoder, the fine function code, forwarding selects and the states of the
// iterative multiply/divide unit.
package alu_pkg;

  // Coarse operation chosen by the main decoder
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP_OR   = 2'b11;

  // Function codes used when the coarse operation defers to CTRL_OP
  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_SLT = 3'b100;
  localparam logic [2:0] CTRL_XOR = 3'b101;
  localparam logic [2:0] CTRL_MUL = 3'b110;
  localparam logic [2:0] CTRL_DIV = 3'b111;

  // Operand forwarding sources; the unused code 2'b11 behaves like FWD_ID
  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multiply/divide sequencer states
  typedef logic [1:0] mdState_t;
  localparam mdState_t MD_IDLE = 2'd0;
  localparam mdState_t MD_BUSY = 2'd1;
  localparam mdState_t MD_DONE = 2'd2;

  // Collapse the two-level opcode into a single function code
  function automatic logic [2:0] effectiveOp(input logic [1:0] aluOp,
                                             input logic [2:0] ctrlOp);
    logic [2:0] op;
    case (aluOp)
      ALU_OP_ADD:  op = CTRL_ADD;
      ALU_OP_SUB:  op = CTRL_SUB;
      ALU_OP_FUNC: op = ctrlOp;
      default:     op = CTRL_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, rstN   clock and asynchronous active-low reset
//   start       begin an operation (honoured only when idle)
//   abort       return to idle immediately, discarding any work in flight
//   op          0 = multiply a*b, 1 = divide a/b
//   a, b        operands, captured on the start cycle
//   busy, done  busy while stepping; done for the single cycle the result is valid
//   lo, hi      product low/high halves or quotient/remainder
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          start,
  input  logic          abort,
  input  logic          op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  localparam logic [5:0] LAST_STEP = 6'(DW - 1);

  mdState_t      state;
  logic [5:0]    count;
  logic          isDiv;
  logic [DW-1:0] operand;
  logic [DW-1:0] hiReg;
  logic [DW-1:0] loReg;
  logic [DW-1:0] hiNext;
  logic [DW-1:0] loNext;
  logic [DW:0]   mulSum;
  logic [DW:0]   divShift;

  // One iteration step. Multiply keeps {hi,lo} as accumulator:multiplier and
  // shifts right after a conditional add. Divide keeps {hi,lo} as
  // remainder:dividend and shifts left, subtracting the divisor when it fits;
  // a zero divisor always fits, which naturally yields an all-ones quotient
  // and leaves the dividend in the remainder.
  always_comb begin
    mulSum   = {1'b0, hiReg};
    divShift = {hiReg, loReg[DW-1]};
    hiNext   = hiReg;
    loNext   = loReg;
    if (loReg[0]) begin
      mulSum = {1'b0, hiReg} + {1'b0, operand};
    end
    if (isDiv) begin
      if (divShift >= {1'b0, operand}) begin
        hiNext = divShift[DW-1:0] - operand;
        loNext = {loReg[DW-2:0], 1'b1};
      end else begin
        hiNext = divShift[DW-1:0];
        loNext = {loReg[DW-2:0], 1'b0};
      end
    end else begin
      hiNext = mulSum[DW:1];
      loNext = {mulSum[0], loReg[DW-1:1]};
    end
  end

  // Sequencer: IDLE -> BUSY for DW steps -> DONE for one cycle -> IDLE.
  // Abort wins over everything so a flushed instruction never completes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= MD_IDLE;
      count   <= '0;
      isDiv   <= 1'b0;
      operand <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else if (abort) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state   <= MD_BUSY;
            count   <= '0;
            isDiv   <= op;
            operand <= b;
            hiReg   <= '0;
            loReg   <= a;
          end
        end
        MD_BUSY: begin
          hiReg <= hiNext;
          loReg <= loNext;
          count <= count + 6'd1;
          if (count == LAST_STEP) begin
            state <= MD_DONE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_DONE);
  assign lo   = loReg;
  assign hi   = hiReg;

endmodule

// File: rtl/alu_ex_stage.sv
// alu_ex_stage
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIV and
// the EX/MEM pipeline register.
// Ports:
//   CLK, RST_n              clock and asynchronous active-low reset
//   Flush                   kill the instruction entering EX/MEM
//   FwdRs, FwdRt            forwarding selects for the two operands
//   Dst_FeedBack            write-back result for forwarding
//   IdEx_*                  ID/EX register contents (control, data, addresses)
//   CTRL_OP                 function code when IdEx_Alu_Op selects it
//   ExMem_*                 EX/MEM register outputs
//   Stall                   freeze the front end while MUL/DIV is running
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          Flush,
  input  logic [1:0]    FwdRs,
  input  logic [1:0]    FwdRt,
  input  logic [DW-1:0] Dst_FeedBack,
  input  logic          IdEx_RegDst,
  input  logic          IdEx_Jump,
  input  logic          IdEx_Branch,
  input  logic          IdEx_MemRead,
  input  logic          IdEx_MemtoReg,
  input  logic          IdEx_MemWrite,
  input  logic          IdEx_ALU_Src,
  input  logic          IdEx_RegWrite,
  input  logic [1:0]    IdEx_Alu_Op,
  input  logic [2:0]    CTRL_OP,
  input  logic [DW-1:0] IdEx_DataRs,
  input  logic [DW-1:0] IdEx_DataRt,
  input  logic [DW-1:0] IdEx_IMM_EX,
  input  logic [AW-1:0] IdEx_AddrRs,
  input  logic [AW-1:0] IdEx_AddrRt,
  input  logic [AW-1:0] IdEx_AddrRd,
  output logic          ExMem_Jump,
  output logic          ExMem_Branch,
  output logic          ExMem_MemRead,
  output logic          ExMem_MemtoReg,
  output logic          ExMem_MemWrite,
  output logic          ExMem_RegWrite,
  output logic [DW-1:0] ExMem_DataRt,
  output logic [AW-1:0] ExMem_AddrRdRt,
  output logic [DW-1:0] ExMem_AluOut,
  output logic [DW-1:0] ExMem_Hi,
  output logic          ExMem_ZeroFlag,
  output logic          Stall
);

  logic [2:0]    effOp;
  logic          isMulDiv;
  logic [DW-1:0] fwdRs;
  logic [DW-1:0] fwdRt;
  logic [DW-1:0] opB;
  logic [DW-1:0] aluResult;
  logic [DW-1:0] resLo;
  logic [DW-1:0] resHi;
  logic          mdBusy;
  logic          mdDone;
  logic          mdIdle;
  logic          holdBubble;
  logic [DW-1:0] mdLo;
  logic [DW-1:0] mdHi;
  logic          unusedAddrRs;

  // Rs address is carried for the hazard unit upstream, not needed here
  assign unusedAddrRs = ^IdEx_AddrRs;

  assign effOp    = effectiveOp(IdEx_Alu_Op, CTRL_OP);
  assign isMulDiv = (effOp == CTRL_MUL) || (effOp == CTRL_DIV);

  // Forwarding muxes; the spare select code falls back to the ID/EX value
  always_comb begin
    case (FwdRs)
      FWD_WB:  fwdRs = Dst_FeedBack;
      FWD_MEM: fwdRs = ExMem_AluOut;
      default: fwdRs = IdEx_DataRs;
    endcase
    case (FwdRt)
      FWD_WB:  fwdRt = Dst_FeedBack;
      FWD_MEM: fwdRt = ExMem_AluOut;
      default: fwdRt = IdEx_DataRt;
    endcase
  end

  assign opB = IdEx_ALU_Src ? IdEx_IMM_EX : fwdRt;

  // Single-cycle ALU; MUL/DIV codes produce zero here since their result
  // comes from the iterative unit
  always_comb begin
    aluResult = '0;
    case (effOp)
      CTRL_ADD: aluResult = fwdRs + opB;
      CTRL_SUB: aluResult = fwdRs - opB;
      CTRL_AND: aluResult = fwdRs & opB;
      CTRL_OR:  aluResult = fwdRs | opB;
      CTRL_SLT: aluResult = {{(DW-1){1'b0}}, ($signed(fwdRs) < $signed(opB))};
      CTRL_XOR: aluResult = fwdRs ^ opB;
      default:  aluResult = '0;
    endcase
  end

  muldiv_iter #(.DW(DW)) uMulDiv (
    .clk   (CLK),
    .rstN  (RST_n),
    .start (isMulDiv),
    .abort (Flush),
    .op    (effOp == CTRL_DIV),
    .a     (fwdRs),
    .b     (opB),
    .busy  (mdBusy),
    .done  (mdDone),
    .lo    (mdLo),
    .hi    (mdHi)
  );

  assign mdIdle = !mdBusy && !mdDone;

  // While a MUL/DIV is starting or stepping, EX/MEM takes bubbles
  assign holdBubble = mdBusy || (mdIdle && isMulDiv);

  // Stall is forced low in reset even if ID/EX presents a MUL/DIV
  assign Stall = RST_n && ((mdIdle && isMulDiv && !Flush) || mdBusy);

  assign resLo = mdDone ? mdLo : aluResult;
  assign resHi = mdDone ? mdHi : '0;

  // EX/MEM register. A bubble clears control but keeps the data fields;
  // a flush clears control yet still loads the data fields.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ExMem_Jump     <= 1'b0;
      ExMem_Branch   <= 1'b0;
      ExMem_MemRead  <= 1'b0;
      ExMem_MemtoReg <= 1'b0;
      ExMem_MemWrite <= 1'b0;
      ExMem_RegWrite <= 1'b0;
      ExMem_DataRt   <= '0;
      ExMem_AddrRdRt <= '0;
      ExMem_AluOut   <= '0;
      ExMem_Hi       <= '0;
      ExMem_ZeroFlag <= 1'b0;
    end else begin
      if (Flush || !holdBubble) begin
        ExMem_DataRt   <= fwdRt;
        ExMem_AddrRdRt <= IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;
        ExMem_AluOut   <= resLo;
        ExMem_Hi       <= resHi;
        ExMem_ZeroFlag <= (resLo == '0);
      end
      if (Flush || holdBubble) begin
        ExMem_Jump     <= 1'b0;
        ExMem_Branch   <= 1'b0;
        ExMem_MemRead  <= 1'b0;
        ExMem_MemtoReg <= 1'b0;
        ExMem_MemWrite <= 1'b0;
        ExMem_RegWrite <= 1'b0;
      end else begin
        ExMem_Jump     <= IdEx_Jump;
        ExMem_Branch   <= IdEx_Branch;
        ExMem_MemRead  <= IdEx_MemRead;
        ExMem_MemtoReg <= IdEx_MemtoReg;
        ExMem_MemWrite <= IdEx_MemWrite;
        ExMem_RegWrite <= IdEx_RegWrite;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage
// Directed vectors for the execute stage. Stimulus pushes expected values,
// tagged with the clock edge after which they must hold, into a scoreboard;
// a monitor on the falling edge pops and compares them.
module tb_alu_ex_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int K_LO    = 0;
  localparam int K_HI    = 1;
  localparam int K_ZERO  = 2;
  localparam int K_CTRL  = 3;
  localparam int K_ADDR  = 4;
  localparam int K_RT    = 5;
  localparam int K_STALL = 6;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          Flush;
  logic [1:0]    FwdRs, FwdRt;
  logic [DW-1:0] Dst_FeedBack;
  logic          IdEx_RegDst, IdEx_Jump, IdEx_Branch, IdEx_MemRead;
  logic          IdEx_MemtoReg, IdEx_MemWrite, IdEx_ALU_Src, IdEx_RegWrite;
  logic [1:0]    IdEx_Alu_Op;
  logic [2:0]    CTRL_OP;
  logic [DW-1:0] IdEx_DataRs, IdEx_DataRt, IdEx_IMM_EX;
  logic [AW-1:0] IdEx_AddrRs, IdEx_AddrRt, IdEx_AddrRd;
  logic          ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg;
  logic          ExMem_MemWrite, ExMem_RegWrite;
  logic [DW-1:0] ExMem_DataRt;
  logic [AW-1:0] ExMem_AddrRdRt;
  logic [DW-1:0] ExMem_AluOut, ExMem_Hi;
  logic          ExMem_ZeroFlag;
  logic          Stall;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } expect_t;

  expect_t sb[$];
  int      edgeCount = 0;
  int      errors    = 0;
  int      checks    = 0;

  always #5 CLK = ~CLK;

  alu_ex_stage #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST_n(RST_n), .Flush(Flush),
    .FwdRs(FwdRs), .FwdRt(FwdRt), .Dst_FeedBack(Dst_FeedBack),
    .IdEx_RegDst(IdEx_RegDst), .IdEx_Jump(IdEx_Jump), .IdEx_Branch(IdEx_Branch),
    .IdEx_MemRead(IdEx_MemRead), .IdEx_MemtoReg(IdEx_MemtoReg),
    .IdEx_MemWrite(IdEx_MemWrite), .IdEx_ALU_Src(IdEx_ALU_Src),
    .IdEx_RegWrite(IdEx_RegWrite), .IdEx_Alu_Op(IdEx_Alu_Op), .CTRL_OP(CTRL_OP),
    .IdEx_DataRs(IdEx_DataRs), .IdEx_DataRt(IdEx_DataRt), .IdEx_IMM_EX(IdEx_IMM_EX),
    .IdEx_AddrRs(IdEx_AddrRs), .IdEx_AddrRt(IdEx_AddrRt), .IdEx_AddrRd(IdEx_AddrRd),
    .ExMem_Jump(ExMem_Jump), .ExMem_Branch(ExMem_Branch),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemtoReg(ExMem_MemtoReg),
    .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite),
    .ExMem_DataRt(ExMem_DataRt), .ExMem_AddrRdRt(ExMem_AddrRdRt),
    .ExMem_AluOut(ExMem_AluOut), .ExMem_Hi(ExMem_Hi),
    .ExMem_ZeroFlag(ExMem_ZeroFlag), .Stall(Stall)
  );

  // Edge counter used to tag scoreboard entries
  always @(posedge CLK) edgeCount++;

  function automatic logic [31:0] sample(input int kind);
    logic [31:0] v;
    case (kind)
      K_LO:    v = ExMem_AluOut;
      K_HI:    v = ExMem_Hi;
      K_ZERO:  v = {31'b0, ExMem_ZeroFlag};
      K_CTRL:  v = {26'b0, ExMem_Jump, ExMem_Branch, ExMem_MemRead,
                    ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite};
      K_ADDR:  v = {27'b0, ExMem_AddrRdRt};
      K_RT:    v = ExMem_DataRt;
      K_STALL: v = {31'b0, Stall};
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input expect_t e);
    logic [31:0] got;
    got = sample(e.kind);
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s edge=%0d got=0x%08h expected=0x%08h",
               e.name, e.cyc, got, e.exp);
    end
  endtask

  // Monitor: compare every entry due at the current edge, flag stale ones
  always @(negedge CLK) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == edgeCount) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < edgeCount) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s missed at edge=%0d", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic pushExpect(input int offset, input int kind,
                            input logic [31:0] v, input string name);
    expect_t e;
    e.cyc  = edgeCount + offset;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] aluOp, input logic [2:0] ctrl,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic regWrite);
    IdEx_Alu_Op   = aluOp;
    CTRL_OP       = ctrl;
    IdEx_DataRs   = rs;
    IdEx_DataRt   = rt;
    IdEx_RegWrite = regWrite;
    IdEx_Jump     = 1'b0;
    IdEx_Branch   = 1'b0;
    IdEx_MemRead  = 1'b0;
    IdEx_MemtoReg = 1'b0;
    IdEx_MemWrite = 1'b0;
    IdEx_ALU_Src  = 1'b0;
    IdEx_IMM_EX   = '0;
    IdEx_RegDst   = 1'b1;
    IdEx_AddrRs   = 5'd1;
    IdEx_AddrRt   = 5'd3;
    IdEx_AddrRd   = 5'd9;
    FwdRs         = FWD_ID;
    FwdRt         = FWD_ID;
    Dst_FeedBack  = '0;
  endtask

  task automatic runVector(input logic [1:0] aluOp, input logic [2:0] ctrl,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp, input string name);
    applyStimulus(aluOp, ctrl, rs, rt, 1'b1);
    pushExpect(1, K_LO, exp, name);
    tick();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired at edge=%0d", edgeCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST_n = 1'b0;
    Flush = 1'b0;
    applyStimulus(ALU_OP_ADD, CTRL_ADD, 0, 0, 1'b0);
    tick();
    tick();
    pushExpect(0, K_CTRL, 0, "reset_ctrl");
    pushExpect(0, K_LO, 0, "reset_aluout");
    pushExpect(0, K_HI, 0, "reset_hi");
    pushExpect(0, K_ZERO, 0, "reset_zero");
    pushExpect(0, K_STALL, 0, "reset_stall");
    tick();
    RST_n = 1'b1;

    // ADD through the function field with RegDst selecting Rd
    applyStimulus(ALU_OP_FUNC, CTRL_ADD, 21, 31, 1'b1);
    pushExpect(0, K_STALL, 0, "add_stall");
    pushExpect(1, K_LO, 52, "add_aluout");
    pushExpect(1, K_HI, 0, "add_hi");
    pushExpect(1, K_ZERO, 0, "add_zero");
    pushExpect(1, K_ADDR, 9, "add_addr");
    pushExpect(1, K_CTRL, 6'b000001, "add_ctrl");
    tick();

    // SUB with Rs from EX/MEM (52) and Rt from write-back (17)
    applyStimulus(ALU_OP_SUB, CTRL_ADD, 1000, 2000, 1'b1);
    FwdRs = FWD_MEM;
    FwdRt = FWD_WB;
    Dst_FeedBack = 17;
    pushExpect(1, K_LO, 35, "fwd_sub_aluout");
    pushExpect(1, K_RT, 17, "fwd_datart");
    tick();

    // Branch compare, then the same with Flush
    applyStimulus(ALU_OP_SUB, CTRL_ADD, 54, 54, 1'b0);
    IdEx_Branch = 1'b1;
    pushExpect(1, K_ZERO, 1, "branch_zero");
    pushExpect(1, K_CTRL, 6'b010000, "branch_ctrl");
    tick();
    Flush = 1'b1;
    pushExpect(1, K_ZERO, 1, "flush_zero");
    pushExpect(1, K_CTRL, 0, "flush_ctrl");
    tick();
    Flush = 1'b0;

    // Remaining single-cycle functions
    runVector(ALU_OP_FUNC, CTRL_SLT, 32'hFFFF_FFFB, 3, 1, "slt_neg");
    runVector(ALU_OP_FUNC, CTRL_SLT, 3, 32'hFFFF_FFFB, 0, "slt_pos");
    runVector(ALU_OP_FUNC, CTRL_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, "and");
    runVector(ALU_OP_FUNC, CTRL_XOR, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, "xor");
    runVector(ALU_OP_FUNC, CTRL_OR, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, "or_func");
    runVector(ALU_OP_FUNC, CTRL_SUB, 10, 3, 7, "sub_func");
    runVector(ALU_OP_OR, CTRL_ADD, 32'h0000_0100, 32'h0000_0001, 32'h0000_0101, "or_aluop");
    runVector(ALU_OP_SUB, CTRL_ADD, 0, 1, 32'hFFFF_FFFF, "sub_wrap");

    // Immediate operand; DataRt still carries the register value
    applyStimulus(ALU_OP_ADD, CTRL_ADD, 10, 5, 1'b1);
    IdEx_ALU_Src = 1'b1;
    IdEx_IMM_EX  = 32'hFFFF_FFFF;
    pushExpect(1, K_LO, 9, "imm_add");
    pushExpect(1, K_RT, 5, "imm_datart");
    tick();

    // Select code 11 falls back to ID/EX data; RegDst=0 picks Rt address
    applyStimulus(ALU_OP_ADD, CTRL_ADD, 7, 8, 1'b1);
    FwdRs = 2'b11;
    FwdRt = 2'b11;
    Dst_FeedBack = 1000;
    IdEx_RegDst = 1'b0;
    pushExpect(1, K_LO, 15, "fwd11_add");
    pushExpect(1, K_ADDR, 3, "regdst_rt");
    tick();

    // MUL: 33 stall cycles with bubbles, then the product
    applyStimulus(ALU_OP_FUNC, CTRL_MUL, 32'h0001_0000, 32'h0003_0000, 1'b1);
    for (int k = 0; k <= 32; k++) pushExpect(k, K_STALL, 1, "mul_stall_hi");
    for (int k = 1; k <= 33; k++) pushExpect(k, K_CTRL, 0, "mul_bubble");
    pushExpect(33, K_STALL, 0, "mul_stall_lo");
    pushExpect(34, K_LO, 0, "mul_lo");
    pushExpect(34, K_HI, 3, "mul_hi");
    pushExpect(34, K_CTRL, 6'b000001, "mul_ctrl");
    repeat (34) tick();

    // DIV 100/7 followed back-to-back by DIV 100/0
    applyStimulus(ALU_OP_FUNC, CTRL_DIV, 100, 7, 1'b1);
    pushExpect(0, K_STALL, 1, "div_stall");
    pushExpect(34, K_LO, 14, "div_quot");
    pushExpect(34, K_HI, 2, "div_rem");
    pushExpect(34, K_ZERO, 0, "div_zero");
    pushExpect(34, K_CTRL, 6'b000001, "div_ctrl");
    repeat (34) tick();
    applyStimulus(ALU_OP_FUNC, CTRL_DIV, 100, 0, 1'b1);
    pushExpect(0, K_STALL, 1, "div0_stall");
    pushExpect(34, K_LO, 32'hFFFF_FFFF, "div0_quot");
    pushExpect(34, K_HI, 100, "div0_rem");
    repeat (34) tick();

    // Flush in BUSY cycle 5; the replacement ADD must run undisturbed
    applyStimulus(ALU_OP_FUNC, CTRL_DIV, 100, 7, 1'b1);
    repeat (5) tick();
    pushExpect(0, K_STALL, 1, "flushdiv_busy");
    pushExpect(1, K_CTRL, 0, "flushdiv_ctrl");
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    applyStimulus(ALU_OP_FUNC, CTRL_ADD, 1, 2, 1'b1);
    for (int k = 0; k < 40; k++) pushExpect(k, K_STALL, 0, "flushdiv_nostall");
    for (int k = 1; k <= 40; k++) begin
      pushExpect(k, K_LO, 3, "flushdiv_aluout");
      pushExpect(k, K_CTRL, 6'b000001, "flushdiv_nowrite");
    end
    repeat (40) tick();

    // Reset asserted mid-BUSY clears everything at once
    applyStimulus(ALU_OP_FUNC, CTRL_MUL, 5, 6, 1'b1);
    repeat (5) tick();
    RST_n = 1'b0;
    pushExpect(0, K_CTRL, 0, "midrst_ctrl");
    pushExpect(0, K_LO, 0, "midrst_aluout");
    pushExpect(0, K_HI, 0, "midrst_hi");
    pushExpect(0, K_ZERO, 0, "midrst_zero");
    pushExpect(0, K_STALL, 0, "midrst_stall");
    tick();
    RST_n = 1'b1;
    applyStimulus(ALU_OP_FUNC, CTRL_ADD, 21, 31, 1'b1);
    pushExpect(0, K_STALL, 0, "postrst_stall");
    pushExpect(1, K_LO, 52, "postrst_add");
    pushExpect(1, K_CTRL, 6'b000001, "postrst_ctrl");
    tick();
    tick();
    tick();

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s never checked (edge=%0d)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Parametrised execute stage for the 5-stage pipeline: forwarding muxes, ALU, EX/MEM pipeline register, and an iterative unsigned multiply/divide unit that stalls the front end while busy. Sits between the ID/EX register and the MEM stage. It generalises the current single-cycle ALU stage in data width and register-address width, and adds MUL/DIV, an upper-result output and a `Stall` handshake.

## Interface
- `DW`, 32, datapath width (≥8)
- `AW`, 5, register address width
- `CLK`  in  1  clock, rising edge
- `RST_n`  in  1  asynchronous, active-low reset
- `Flush`  in  1  synchronous; kill instruction entering EX/MEM
- `FwdRs`, `FwdRt`  in  2  00 ID/EX data, 01 `Dst_FeedBack`, 10 `ExMem_AluOut`, 11 treated as 00
- `Dst_FeedBack`  in  DW  WB-stage result
- `IdEx_RegDst`, `IdEx_Jump`, `IdEx_Branch`, `IdEx_MemRead`, `IdEx_MemtoReg`, `IdEx_MemWrite`, `IdEx_ALU_Src`, `IdEx_RegWrite`  in  1 each  control
- `IdEx_Alu_Op`  in  2  00 ADD, 01 SUB, 10 per `CTRL_OP`, 11 OR
- `CTRL_OP`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 XOR, 110 MUL, 111 DIV
- `IdEx_DataRs`, `IdEx_DataRt`, `IdEx_IMM_EX`  in  DW
- `IdEx_AddrRs`, `IdEx_AddrRt`, `IdEx_AddrRd`  in  AW
- `ExMem_Jump`, `ExMem_Branch`, `ExMem_MemRead`, `ExMem_MemtoReg`, `ExMem_MemWrite`, `ExMem_RegWrite`  out  1  registered control
- `ExMem_DataRt`  out  DW  forwarded Rt (before ALU_Src mux)
- `ExMem_AddrRdRt`  out  AW  `RegDst ? Rd : Rt`
- `ExMem_AluOut`  out  DW  result; MUL low half, DIV quotient
- `ExMem_Hi`  out  DW  MUL high half, DIV remainder, 0 otherwise
- `ExMem_ZeroFlag`  out  1  `ExMem_AluOut == 0`
- `Stall`  out  1  hold PC/IF/ID and ID/EX stable

## Operation
- A = forwarded Rs; B = `ALU_Src ? IMM_EX : forwarded Rt`. All arithmetic is modulo 2^DW; no overflow flag. SLT yields 1/0, signed compare.
- Single-cycle ops: EX/MEM loads on every rising edge when FSM is IDLE and the op is not MUL/DIV.
- MUL/DIV FSM, states IDLE, BUSY, DONE:
  - IDLE with MUL/DIV present and `Flush`=0: latch A, B; clear 6-bit iteration counter; go BUSY. EX/MEM loads a bubble.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. After DW steps, go DONE. EX/MEM loads a bubble each cycle.
  - DONE: EX/MEM loads the result with the instruction's control bits, then IDLE. ID/EX still holds the same instruction, which is not restarted.
- `Stall` = (IDLE and MUL/DIV present and not `Flush`) or BUSY. It is combinational from state and `CTRL_OP`/`Alu_Op`.
- DIV by 0: quotient all-ones, remainder = dividend.
- Bubble: all six control outputs 0. Data and address registers keep their previous values.
- `Flush`=1 at an edge:
  - EX/MEM control bits load 0; data loads normally.
  - FSM is forced to IDLE from any state, aborting MUL/DIV without writeback.
  - Flush has priority over start and DONE.
- Reset: all outputs 0, FSM IDLE, counter 0. Asserting reset mid-BUSY aborts immediately; `Stall` is 0 during reset.

## Timing
- Single-cycle op: 1-cycle latency, inputs at edge N appear on outputs after edge N.
- MUL/DIV presented at cycle 0: `Stall` high for cycles 0..DW (DW+1 cycles); result visible after the edge ending cycle DW+1. DW=32 gives 33 stall cycles.
- Forwarding source `10` reads the registered `ExMem_AluOut`. Operands are sampled only at the start cycle, so later forwarding changes do not affect MUL/DIV.
- Back-to-back MUL/DIV: the second one starts in the cycle after DONE.

## Structure
- Shared package `alu_pkg`:
  - `ALU_OP_*` and `CTRL_*` encodings
  - `FWD_ID`, `FWD_WB`, `FWD_MEM`
  - FSM state typedef (IDLE/BUSY/DONE)
- One sub-module, `muldiv_iter`:
  - inputs: start, abort, op, a, b
  - outputs: busy, done, lo, hi
  - contains the FSM, counter and shift registers
- Top level holds forwarding muxes, ALU and EX/MEM registers.

## Test plan
- Reset: drive `RST_n`=0 mid-BUSY → all outputs 0 and `Stall`=0 immediately; after release the next ADD completes normally.
- ADD: `Alu_Op`=10, `CTRL_OP`=000, Rs=21, Rt=31, `RegDst`=1, Rd=9 → `AluOut`=52, `AddrRdRt`=9, `Zero`=0, `Hi`=0, `RegWrite`=1.
- Forwarding: previous `AluOut`=52, `FwdRs`=10, `FwdRt`=01, `Dst_FeedBack`=17, SUB → `AluOut`=35, `DataRt`=17.
- Branch plus flush: `Alu_Op`=01, Rs=Rt=54, `Branch`=1 → `Zero`=1, `Branch`=1. Same stimulus with `Flush`=1 → all control outputs 0.
- MUL: 0x00010000 × 0x00030000 → `Stall` high 33 cycles with `RegWrite`=0 throughout, then `AluOut`=0, `Hi`=3, `RegWrite`=1.
- DIV:
  - 100/7 → `AluOut`=14, `Hi`=2.
  - 100/0 → `AluOut`=0xFFFFFFFF, `Hi`=100.
  - `Flush` in BUSY cycle 5 → `Stall`=0 the next cycle and no result is written.
